// File: rtl/types_pkg.sv
// Shared types for the memory-access stage: memory-control codes, FSM states
// and the width of the access timeout counter.
package types_pkg;

  typedef enum logic [1:0] {
    MEMC_NONE  = 2'd0,
    MEMC_LOAD  = 2'd1,
    MEMC_STORE = 2'd2,
    MEMC_RSVD  = 2'd3
  } memc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int TIMEOUT_W = 8;

  // RSVD deliberately falls out as a non-memory instruction.
  function automatic logic is_mem_op(input logic [1:0] code);
    return (code == MEMC_LOAD) || (code == MEMC_STORE);
  endfunction

endpackage

// File: rtl/stage_three_memif.sv
// Data-memory interface: access FSM, timeout counter, registered request
// signals and the hold register for load data acked while the system is halted.
module stage_three_memif
  import types_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic [1:0]        memc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              fin_ok,
  output logic              fin_err,
  output logic [DATA_W-1:0] ld_data,
  output logic [1:0]        state_dbg
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  mem_state_e          state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                start;
  logic                timeout;

  assign start   = (state_q == IDLE) && !halt_sys && is_mem_op(memc);
  // The counter reads k-1 in the k-th BUSY cycle, so this fires in BUSY cycle TIMEOUT.
  assign timeout = (state_q == BUSY) && !mem_ack && !halt_sys && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY: begin
        if (mem_ack)      state_d = halt_sys ? DONE : IDLE;
        else if (timeout) state_d = IDLE;
      end
      DONE:    if (!halt_sys) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = 1'b1;
          we_d    = (memc == MEMC_STORE);
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (halt_sys) hold_d = mem_rdata;
        end else if (timeout) begin
          req_d = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    ld_data = mem_rdata;
    case (state_q)
      IDLE: stall = start;
      BUSY: begin
        fin_ok  = mem_ack && !halt_sys;
        fin_err = timeout;
        stall   = !fin_ok && !timeout;
      end
      DONE: begin
        stall   = halt_sys;
        fin_ok  = !halt_sys;
        ld_data = hold_q;
      end
      default: ;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/stage_three.sv
// Memory-access pipeline stage: runs loads/stores through the memory interface
// and registers the selected result into the writeback pipeline flop.
module stage_three
  import types_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic [1:0]        in_memc,
  input  logic [31:0]       in_alu,
  input  logic [15:0]       in_R1_data,
  input  logic              in_R0_en,
  input  logic [15:0]       in_instr,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       out_result,
  output logic              out_R0_en,
  output logic [15:0]       out_instr,
  output logic              out_valid,
  output logic              out_bus_err
);

  logic              stall;
  logic              fin_ok;
  logic              fin_err;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        state_dbg;

  logic [31:0] result_q, result_d;
  logic        r0_en_q, r0_en_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        bus_err_q, bus_err_d;

  stage_three_memif #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) u_memif (
    .clk      (clk),
    .rst      (rst),
    .halt_sys (halt_sys),
    .memc     (in_memc),
    .addr     (in_alu[ADDR_W-1:0]),
    .wdata    (in_R1_data[DATA_W-1:0]),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .stall    (stall),
    .fin_ok   (fin_ok),
    .fin_err  (fin_err),
    .ld_data  (ld_data),
    .state_dbg(state_dbg)
  );

  // Gated by rst so the stall releases together with the async reset.
  assign stall_out = stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      r0_en_q   <= 1'b0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      r0_en_q   <= r0_en_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    result_d  = result_q;
    r0_en_d   = r0_en_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    bus_err_d = bus_err_q;
    if (!halt_sys) begin
      if (fin_ok) begin
        result_d  = (in_memc == MEMC_LOAD) ? {{(32-DATA_W){1'b0}}, ld_data} : in_alu;
        r0_en_d   = in_R0_en;
        instr_d   = in_instr;
        valid_d   = 1'b1;
        bus_err_d = 1'b0;
      end else if (fin_err) begin
        result_d  = '0;
        r0_en_d   = 1'b0;
        instr_d   = in_instr;
        valid_d   = 1'b1;
        bus_err_d = 1'b1;
      end else if ((state_dbg == IDLE) && !is_mem_op(in_memc)) begin
        result_d  = in_alu;
        r0_en_d   = in_R0_en;
        instr_d   = in_instr;
        valid_d   = 1'b1;
        bus_err_d = 1'b0;
      end else begin
        result_d  = '0;
        r0_en_d   = 1'b0;
        instr_d   = '0;
        valid_d   = 1'b0;
        bus_err_d = 1'b0;
      end
    end
  end

  assign out_result  = result_q;
  assign out_R0_en   = r0_en_q;
  assign out_instr   = instr_q;
  assign out_valid   = valid_q;
  assign out_bus_err = bus_err_q;

endmodule

// File: doc/stage_three.md
Name: stage_three

Overview:
- Memory-access stage of the 16-bit pipeline. Sits directly downstream of the execute (ALU) stage flop and feeds the writeback stage.
- Consumes the execute stage's memory-control code, 32-bit ALU result, R1 store data, R0 enable and instruction word.
- Performs data-memory loads and stores over a req/ack handshake, stalling upstream while a transfer is outstanding.
- Registers the result into the writeback pipeline flop.

Parameters:
- ADDR_W, 16, data-memory address width; address is in_alu[ADDR_W-1:0].
- DATA_W, 16, data-memory word width.
- TIMEOUT, 255, maximum BUSY cycles without mem_ack before the access is aborted (8-bit counter).

Ports:
- clk  in  1  system clock, all flops on posedge.
- rst  in  1  asynchronous, active-high reset.
- halt_sys  in  1  global halt; freezes the pipeline flop and blocks new requests.
- in_memc  in  types_pkg::memc_t (2)  memory-control code from execute stage.
- in_alu  in  32  ALU result; low ADDR_W bits are the memory address.
- in_R1_data  in  16  store data.
- in_R0_en  in  1  R0 write enable, passed through.
- in_instr  in  16  instruction word, passed through.
- stall_out  out  1  combinational; upstream holds its flop while high.
- mem_req  out  1  registered request.
- mem_we  out  1  registered; 1 = store.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered store data.
- mem_rdata  in  DATA_W  load data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.
- out_result  out  32  load data zero-extended, otherwise in_alu.
- out_R0_en  out  1  registered pass-through.
- out_instr  out  16  registered pass-through.
- out_valid  out  1  1 = real instruction, 0 = bubble.
- out_bus_err  out  1  1 for the committed slot of a timed-out access.

Behaviour:
- Reset (async): state=IDLE, counter=0, mem_req/mem_we=0, mem_addr/mem_wdata=0. All out_* = 0. Reset mid-transfer drops mem_req immediately.
- memc encoding (types_pkg): MEMC_NONE=0, MEMC_LOAD=1, MEMC_STORE=2, MEMC_RSVD=3. RSVD is treated as NONE.
- States: IDLE, BUSY, DONE.
- IDLE, halt_sys=1: everything holds; stall_out=0; no request started.
- IDLE, memc NONE/RSVD: stall_out=0. Flop loads result=in_alu, R0_en, instr, valid=1, bus_err=0. Latency 1.
- IDLE, memc LOAD/STORE: stall_out=1; state→BUSY.
  - Next cycle: mem_req=1, mem_we=(STORE), mem_addr=in_alu[15:0], mem_wdata=in_R1_data, counter=0.
  - Flop loads a bubble: valid=0, R0_en=0, instr=0, result=0, bus_err=0.
- BUSY, mem_ack=0: stall_out=1; counter++; mem_* held stable; flop holds bubble.
- BUSY, mem_ack=1, halt_sys=0: stall_out=0; mem_req→0; state→IDLE.
  - Flop loads result = LOAD ? {16'd0, mem_rdata} : in_alu, plus in_R0_en, in_instr, valid=1.
- BUSY, mem_ack=1, halt_sys=1: mem_req→0; rdata captured to hold register; state→DONE; stall_out=1.
- DONE: stall_out=1 while halt_sys=1. When halt_sys=0: commit as for ack using the held rdata; stall_out=0; state→IDLE.
- BUSY, counter reaches TIMEOUT with no ack:
  - mem_req→0; stall_out=0 that cycle; state→IDLE.
  - Flop loads result=0, valid=1, bus_err=1, R0_en=0, instr=in_instr.
- mem_ack in IDLE or DONE is ignored.
- Minimum load/store occupancy is 2 cycles (1 stall cycle). Each memory instruction issues exactly one request.
- Inputs are stable whenever stall_out=1, because upstream is held.

Decomposition:
- types_pkg: memc_t enum values above; mem_state_e {IDLE, BUSY, DONE}; TIMEOUT_W=8 constant.
- Optional sub-module stage_three_memif holds the FSM, timeout counter, request registers and rdata hold register. stage_three keeps the pipeline flop and the result mux.

Test Plan:
- ALU pass-through: memc=NONE, in_alu=32'h0001_2345, instr=16'hA1B2 → next cycle out_result=32'h0001_2345, out_valid=1, stall_out never asserted.
- Load, ack after 3 cycles: memc=LOAD, in_alu=16'h0040, mem_rdata=16'hBEEF → mem_req=1 for 3 cycles with addr=16'h0040 and we=0, stall_out high for 3 cycles, then out_result=32'h0000_BEEF, out_valid=1.
- Store, immediate ack: memc=STORE, in_alu=16'h0010, in_R1_data=16'h1234, ack on first req cycle → mem_we=1, mem_wdata=16'h1234, one stall cycle, out_result=in_alu.
- Halt during BUSY: ack arrives with halt_sys=1, rdata=16'h00FF → state DONE, outputs frozen. After halt drops, out_result=32'h0000_00FF, stall_out falls the same cycle.
- Timeout: LOAD with ack never asserted → mem_req drops after 255 BUSY cycles, out_bus_err=1, out_R0_en=0, out_result=0.
- Reset mid-BUSY: assert rst two cycles into a load → mem_req=0 and all outputs 0 without waiting for a clock edge. After release, a NONE instruction completes normally.
